// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
//    Shares the single-port main data RAM between the processor load/store
//    path (p_*) and a debug/loader port (d_*). Exactly one requester is granted
//    per cycle, combinationally from the requests and the FSM state. Read data
//    comes back one cycle after the grant, registered, with a one-cycle valid.
//
//    Ports
//       clock, n_reset            system clock, synchronous active-low reset
//       p_req/p_we/p_addr/p_wdata processor request
//       p_stall                   processor requesting but not granted
//       p_rdata/p_rvalid          processor read return
//       d_req/d_we/d_addr/d_wdata debug request
//       d_gnt                     debug granted this cycle
//       d_rdata/d_rvalid          debug read return
//       m_addr/m_data/m_wren/m_q  RAM port (RAM clocked on ~clock)
//
//    state  | meaning
//    S_PROC | processor favoured; debug wins contention after WAIT_MAX waits
//    S_DBG  | debug burst under way; debug keeps the port up to DBG_BURST grants
module main_mem_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 16,
   parameter int WAIT_MAX  = 3,
   parameter int DBG_BURST = 4
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_stall,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_rvalid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data,
   output logic              m_wren,
   input  logic [DATA_W-1:0] m_q
);

   localparam logic [3:0] WAIT_MAX_C  = 4'(WAIT_MAX);
   localparam logic [3:0] DBG_BURST_C = 4'(DBG_BURST);

   typedef enum logic {S_PROC, S_DBG} state_t;
   typedef enum logic [1:0] {LR_NONE, LR_P, LR_D} last_rd_t;

   state_t            state_q, state_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [3:0]        burst_cnt_q, burst_cnt_d;
   last_rd_t          last_rd_q, last_rd_d;
   logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              p_grant, d_grant;

   // Grants are forced off while reset is low so nothing reaches the RAM.
   always_comb begin
      p_grant = 1'b0;
      d_grant = 1'b0;
      if (n_reset) begin
         if (p_req && d_req) begin
            if (state_q == S_DBG || wait_cnt_q == WAIT_MAX_C) d_grant = 1'b1;
            else                                              p_grant = 1'b1;
         end else if (p_req) begin
            p_grant = 1'b1;
         end else if (d_req) begin
            d_grant = 1'b1;
         end
      end
   end

   always_comb begin
      m_addr  = d_grant ? d_addr  : p_addr;
      m_data  = d_grant ? d_wdata : p_wdata;
      m_wren  = d_grant ? d_we    : (p_grant & p_we);
      p_stall = p_req & ~p_grant;
      d_gnt   = d_grant;
   end

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      wait_cnt_d  = wait_cnt_q;

      if (d_grant || !d_req)           wait_cnt_d = 4'd0;
      else if (wait_cnt_q != WAIT_MAX_C) wait_cnt_d = wait_cnt_q + 4'd1;

      case (state_q)
         S_PROC: begin
            // A contended debug win opens a burst; a burst limit of one
            // means the burst is already complete, so stay put.
            if (d_grant && p_req) begin
               if (DBG_BURST_C == 4'd1) begin
                  burst_cnt_d = 4'd0;
               end else begin
                  state_d     = S_DBG;
                  burst_cnt_d = 4'd1;
               end
            end
         end
         S_DBG: begin
            if (!d_req) begin
               state_d     = S_PROC;
               burst_cnt_d = 4'd0;
            end else if (d_grant) begin
               // burst_cnt counts grants already taken; leave once this one
               // brings the burst up to the limit.
               if (burst_cnt_q + 4'd1 == DBG_BURST_C) begin
                  state_d     = S_PROC;
                  burst_cnt_d = 4'd0;
               end else begin
                  burst_cnt_d = burst_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = S_PROC;
      endcase

      last_rd_d = LR_NONE;
      if (p_grant && !p_we)      last_rd_d = LR_P;
      else if (d_grant && !d_we) last_rd_d = LR_D;

      // RAM updates m_q on the falling edge, so it is valid at the rising
      // edge that ends the grant cycle.
      p_rdata_d = (last_rd_d == LR_P) ? m_q : p_rdata_q;
      d_rdata_d = (last_rd_d == LR_D) ? m_q : d_rdata_q;
   end

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state_q     <= S_PROC;
         wait_cnt_q  <= 4'd0;
         burst_cnt_q <= 4'd0;
         last_rd_q   <= LR_NONE;
         p_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         last_rd_q   <= last_rd_d;
         p_rdata_q   <= p_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign p_rdata  = p_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign p_rvalid = (last_rd_q == LR_P);
   assign d_rvalid = (last_rd_q == LR_D);

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Shares the single-port main data RAM between the processor's load/store path and a debug/loader port (memory inspector or program loader driven from switches or a host link). It sits between `processor` and the main `ram_inc` instance in `hardware`. Per cycle it grants exactly one requester, drives the RAM port, and returns registered read data with a valid pulse. The processor has priority, bounded by an anti-starvation rule and a burst limit for the debug side.

## Interface
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 16, RAM data width
- `WAIT_MAX`, 3, contended cycles a debug request waits before it wins (1..15)
- `DBG_BURST`, 4, max consecutive debug grants under contention (1..15)

- `clock`  in  1  single system clock; all state updates on rising edge
- `n_reset`  in  1  synchronous, active-low reset
- `p_req`  in  1  processor access request
- `p_we`  in  1  processor write (1) / read (0)
- `p_addr`  in  ADDR_W  processor address
- `p_wdata`  in  DATA_W  processor write data
- `p_stall`  out  1  processor request present but not granted this cycle
- `p_rdata`  out  DATA_W  registered processor read data
- `p_rvalid`  out  1  one-cycle pulse: `p_rdata` is new
- `d_req`, `d_we`, `d_addr`, `d_wdata`  in  1/1/ADDR_W/DATA_W  debug request, same meaning as the processor signals
- `d_gnt`  out  1  debug request granted this cycle
- `d_rdata`  out  DATA_W  registered debug read data
- `d_rvalid`  out  1  one-cycle pulse: `d_rdata` is new
- `m_addr`  out  ADDR_W  RAM address
- `m_data`  out  DATA_W  RAM write data
- `m_wren`  out  1  RAM write enable
- `m_q`  in  DATA_W  RAM read data (RAM clocked on `~clock`)

## Operation
- FSM states: `S_PROC` (processor favoured), `S_DBG` (debug burst in progress). Registers: `wait_cnt` (4 bit), `burst_cnt` (4 bit), `last_rd` (none/P/D).
- Grant is combinational from `p_req`, `d_req`, and state:
  - Neither requests: no grant; `m_addr=p_addr`, `m_data=p_wdata`, `m_wren=0`.
  - One requests: that requester is granted.
  - Both request in `S_PROC`: debug is granted iff `wait_cnt==WAIT_MAX`, else the processor is granted.
  - Both request in `S_DBG`: debug is granted.
- The granted requester's addr/wdata/we drive `m_addr`/`m_data`/`m_wren`. `p_stall = p_req & ~p_grant`. `d_gnt = debug granted`.
- `wait_cnt`: +1 (saturating at WAIT_MAX) on each cycle with `d_req` high and no debug grant; cleared on debug grant or `d_req` low.
- Transition `S_PROC->S_DBG`: debug granted under contention. `burst_cnt` is set to 1.
- In `S_DBG`, each debug grant does `burst_cnt+1`.
- Transition `S_DBG->S_PROC`: `d_req` low, or `burst_cnt==DBG_BURST` at a granted cycle. The next cycle then grants the processor if it requests.
- Debug-only grants in `S_PROC` (no contention) do not enter `S_DBG`.
- Read return: at the rising edge ending a read-grant cycle, `m_q` is valid. The owner's rdata register loads `m_q` and its rvalid is set for exactly one cycle. Rdata holds until the next read for that requester.
- Writes produce no rvalid.
- Requesters hold addr/we/wdata stable while stalled or not granted.

## Timing
- Grant and RAM drive: same cycle as request (0 latency). Read data and rvalid: 1 cycle after grant.
- Back-to-back reads by one requester give rvalid high on consecutive cycles with new data each cycle.
- Worst-case debug wait under continuous processor traffic: WAIT_MAX cycles.
- Worst-case processor stall: DBG_BURST cycles.
- Reset (`n_reset` low at a rising edge) puts the block in `S_PROC` with `wait_cnt=0`, `burst_cnt=0`, `p_rdata=0`, `d_rdata=0`, `p_rvalid=0`, `d_rvalid=0`.
- While `n_reset` is low: `m_wren=0`, `d_gnt=0`, `p_stall=p_req`.
- Reset asserted mid-burst or with a read outstanding discards the pending rvalid. No write is issued during reset.

## Test plan
- Processor only: read addr 0x010 (RAM holds 0x1234) -> `p_stall=0`. One cycle later `p_rvalid=1`, `p_rdata=0x1234`, `d_rvalid` stays 0.
- Debug only: write 0xBEEF to 0x0FF, then read 0x0FF -> `d_gnt=1` on both cycles, `m_wren=1` only on the first. `d_rdata=0xBEEF` with `d_rvalid` one cycle after the read.
- Contention: `p_req` and `d_req` held high continuously (defaults) -> processor granted 3 cycles, then debug 4 cycles, then processor 3 cycles. The 3/4 pattern repeats; `p_stall` is high exactly during debug cycles.
- Simultaneous arrival with `d_req` dropping after 2 debug grants -> FSM returns to `S_PROC` and the processor is granted the next cycle; `wait_cnt=0`.
- Saturation: `WAIT_MAX=1`, `DBG_BURST=1` with both requesting -> grants strictly alternate P,D,P,D…
- Reset mid-burst: assert `n_reset=0` during the 2nd debug grant with a read outstanding -> next cycle `d_rvalid=0`, `m_wren=0`, and all registers are at their reset values. After release, the processor is granted first under contention.
